// File: rtl/uart_tx_frame_engine.sv
// rtl/uart_tx_frame_engine.sv - UART transmit frame engine with holding register and per-bit divider
// Optional line-break generator enabled by defining UART_TX_BREAK_EN.
module uart_tx_frame_engine #(
   parameter int MAX_DATA_BITS = 9,
   parameter int DIV_W         = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DIV_W-1:0]         cfg_div,
   input  logic [3:0]               cfg_data_bits,
   input  logic [2:0]               cfg_parity,
   input  logic                     cfg_stop2,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [MAX_DATA_BITS-1:0] s_data,
`ifdef UART_TX_BREAK_EN
   input  logic                     brk_req,
   output logic                     brk_active,
`endif
   output logic                     tx,
   output logic                     busy,
   output logic                     frame_done,
   output logic                     cfg_err
);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
`ifdef UART_TX_BREAK_EN
      , S_BREAK, S_BRK_STOP
`endif
   } state_t;

   localparam logic [3:0] MAX_BITS = 4'(MAX_DATA_BITS);

   state_t                   state;
   logic                     hold_full;
   logic [MAX_DATA_BITS-1:0] hold_data;
   logic [MAX_DATA_BITS-1:0] shift_reg;
   logic [MAX_DATA_BITS-1:0] data_mask;
   logic [3:0]               bit_cnt;
   logic [DIV_W-1:0]         div_cnt;
   // per-frame snapshot of the CSR configuration
   logic [DIV_W-1:0]         f_div;
   logic [3:0]               f_bits;
   logic                     f_par_en;
   logic                     f_par_bit;
   logic                     f_stop2;

   logic bit_end, accept, cfg_ok, last_stop, frame_end, launch, brk_take, new_par;

`ifdef UART_TX_BREAK_EN
   logic [4:0] brk_cnt;
   logic       brk_end;
   assign brk_take  = brk_req && (state == S_IDLE);
   assign brk_end   = bit_end && (state == S_BRK_STOP);
   assign frame_end = last_stop || brk_end;
`else
   assign brk_take  = 1'b0;
   assign frame_end = last_stop;
`endif

   always_comb begin
      data_mask = '0;
      for (int i = 0; i < MAX_DATA_BITS; i++)
         data_mask[i] = (i < int'(cfg_data_bits));
      new_par = 1'b0;
      case (cfg_parity)
         3'd1:    new_par = ^(hold_data & data_mask);
         3'd2:    new_par = ~^(hold_data & data_mask);
         3'd3:    new_par = 1'b1;
         default: new_par = 1'b0;
      endcase
   end

   assign bit_end   = (div_cnt == '0);
   assign accept    = s_valid && !hold_full;
   assign cfg_ok    = (cfg_data_bits >= 4'd5) && (cfg_data_bits <= MAX_BITS) && (cfg_parity <= 3'd4);
   assign last_stop = bit_end && (((state == S_STOP1) && !f_stop2) || (state == S_STOP2));
   // a held word starts either from idle or straight after the last stop bit, with no gap
   assign launch    = hold_full && (((state == S_IDLE) && !brk_take) || frame_end);
   assign s_ready   = !hold_full;
   assign busy      = (state != S_IDLE) || hold_full;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         hold_full  <= 1'b0;
         hold_data  <= '0;
         shift_reg  <= '0;
         bit_cnt    <= '0;
         div_cnt    <= '0;
         f_div      <= '0;
         f_bits     <= '0;
         f_par_en   <= 1'b0;
         f_par_bit  <= 1'b0;
         f_stop2    <= 1'b0;
         tx         <= 1'b1;
         frame_done <= 1'b0;
         cfg_err    <= 1'b0;
`ifdef UART_TX_BREAK_EN
         brk_cnt    <= '0;
         brk_active <= 1'b0;
`endif
      end else begin
         frame_done <= last_stop;
         if (accept) begin
            hold_full <= 1'b1;
            hold_data <= s_data;
         end
         if (state != S_IDLE)
            div_cnt <= bit_end ? f_div : div_cnt - DIV_W'(1);

         case (state)
            S_IDLE: begin
`ifdef UART_TX_BREAK_EN
               if (brk_req) begin
                  state      <= S_BREAK;
                  tx         <= 1'b0;
                  brk_active <= 1'b1;
                  f_div      <= cfg_div;
                  div_cnt    <= cfg_div;
                  brk_cnt    <= 5'(cfg_data_bits) + 5'(cfg_parity != 3'd0) + 5'(cfg_stop2) + 5'd2;
               end
`endif
            end
            S_START: if (bit_end) begin
               state     <= S_DATA;
               tx        <= shift_reg[0];
               shift_reg <= shift_reg >> 1;
               bit_cnt   <= '0;
            end
            S_DATA: if (bit_end) begin
               if (bit_cnt == f_bits - 4'd1) begin
                  if (f_par_en) begin
                     state <= S_PARITY;
                     tx    <= f_par_bit;
                  end else begin
                     state <= S_STOP1;
                     tx    <= 1'b1;
                  end
               end else begin
                  bit_cnt   <= bit_cnt + 4'd1;
                  tx        <= shift_reg[0];
                  shift_reg <= shift_reg >> 1;
               end
            end
            S_PARITY: if (bit_end) begin
               state <= S_STOP1;
               tx    <= 1'b1;
            end
            S_STOP1: if (bit_end) state <= f_stop2 ? S_STOP2 : S_IDLE;
            S_STOP2: if (bit_end) state <= S_IDLE;
`ifdef UART_TX_BREAK_EN
            S_BREAK: if (bit_end) begin
               if (brk_cnt == 5'd1) begin
                  state <= S_BRK_STOP;
                  tx    <= 1'b1;
               end else begin
                  brk_cnt <= brk_cnt - 5'd1;
               end
            end
            S_BRK_STOP: if (bit_end) begin
               state      <= S_IDLE;
               brk_active <= 1'b0;
            end
`endif
            default: state <= S_IDLE;
         endcase

         // illegal config drops the word; the line stays idle-high
         if (launch) begin
            hold_full <= 1'b0;
            if (cfg_ok) begin
               state     <= S_START;
               tx        <= 1'b0;
               shift_reg <= hold_data;
               div_cnt   <= cfg_div;
               f_div     <= cfg_div;
               f_bits    <= cfg_data_bits;
               f_par_en  <= (cfg_parity != 3'd0);
               f_par_bit <= new_par;
               f_stop2   <= cfg_stop2;
            end else begin
               cfg_err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// tb/tb_uart_tx_frame_engine.sv - self-checking bench for uart_tx_frame_engine
module tb_uart_tx_frame_engine;
   localparam int MDB = 9;
   localparam int DW  = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst = 1'b1;
   logic [DW-1:0]  cfg_div = '0;
   logic [3:0]     cfg_data_bits = 4'd8;
   logic [2:0]     cfg_parity = 3'd0;
   logic           cfg_stop2 = 1'b0;
   logic           s_valid = 1'b0;
   logic           s_ready;
   logic [MDB-1:0] s_data = '0;
   logic           tx, busy, frame_done, cfg_err;
   logic           brk_req = 1'b0;
   logic           brk_active;

   uart_tx_frame_engine #(.MAX_DATA_BITS(MDB), .DIV_W(DW)) dut (
      .clk(clk), .rst(rst), .cfg_div(cfg_div), .cfg_data_bits(cfg_data_bits),
      .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .s_valid(s_valid),
      .s_ready(s_ready), .s_data(s_data),
`ifdef UART_TX_BREAK_EN
      .brk_req(brk_req), .brk_active(brk_active),
`endif
      .tx(tx), .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
   );
`ifndef UART_TX_BREAK_EN
   assign brk_active = 1'b0;
`endif

   int errors = 0;
   int checks = 0;

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   task automatic chkn(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Model: the line as a queue of per-clock levels, built from frame rules at launch time.
   typedef struct packed { logic tx; logic last; logic brk; } ent_t;
   ent_t           q[$];
   logic           m_hold = 1'b0;
   logic [MDB-1:0] m_data = '0;
   logic           m_err = 1'b0;
   logic           m_done = 1'b0;
   logic           m_idle, m_end, m_acc;
   ent_t           m_e;
   int             cyc = 0;
   bit             chk_en = 1'b0;
   int             done_t[$];

   task automatic push_frame(input logic [MDB-1:0] w);
      logic seq[$];
      logic x;
      x = 1'b0;
      seq.push_back(1'b0);
      for (int i = 0; i < int'(cfg_data_bits); i++) begin
         seq.push_back(w[i]);
         x ^= w[i];
      end
      case (cfg_parity)
         3'd1: seq.push_back(x);
         3'd2: seq.push_back(~x);
         3'd3: seq.push_back(1'b1);
         3'd4: seq.push_back(1'b0);
         default: ;
      endcase
      seq.push_back(1'b1);
      if (cfg_stop2) seq.push_back(1'b1);
      for (int j = 0; j < seq.size(); j++)
         for (int k = 0; k <= int'(cfg_div); k++)
            q.push_back(ent_t'{tx: seq[j], last: (j == seq.size() - 1) && (k == int'(cfg_div)), brk: 1'b0});
   endtask

   task automatic push_break();
      int n;
      n = int'(cfg_data_bits) + ((cfg_parity != 3'd0) ? 1 : 0) + (cfg_stop2 ? 1 : 0) + 2;
      for (int b = 0; b < n * (int'(cfg_div) + 1); b++) q.push_back(ent_t'{tx: 1'b0, last: 1'b0, brk: 1'b1});
      for (int k = 0; k <= int'(cfg_div); k++) q.push_back(ent_t'{tx: 1'b1, last: 1'b0, brk: 1'b1});
   endtask

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst) begin
         q.delete();
         m_hold = 1'b0;
         m_err  = 1'b0;
         m_done = 1'b0;
      end else begin
         m_idle = (q.size() == 0);
         m_end  = 1'b0;
         m_done = 1'b0;
         m_acc  = s_valid && !m_hold;
         if (!m_idle) begin
            m_e    = q.pop_front();
            m_done = m_e.last;
            m_end  = (q.size() == 0);
         end
         if (m_idle && brk_req) begin
            push_break();
         end else if ((m_idle || m_end) && m_hold) begin
            m_hold = 1'b0;
            if (cfg_data_bits >= 4'd5 && int'(cfg_data_bits) <= MDB && cfg_parity <= 3'd4)
               push_frame(m_data);
            else
               m_err = 1'b1;
         end
         if (m_acc) begin
            m_hold = 1'b1;
            m_data = s_data;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk1("tx", tx, (q.size() > 0) ? q[0].tx : 1'b1);
         chk1("busy", busy, (q.size() > 0) || m_hold);
         chk1("s_ready", s_ready, !m_hold);
         chk1("frame_done", frame_done, m_done);
         chk1("cfg_err", cfg_err, m_err);
`ifdef UART_TX_BREAK_EN
         chk1("brk_active", brk_active, (q.size() > 0) && q[0].brk);
`endif
         if (frame_done === 1'b1) done_t.push_back(cyc);
      end
   end

   logic cap_tx[0:63];
   logic cap_done[0:63];
   logic cap_busy[0:63];
   logic cap_brk[0:63];

   task automatic send(input logic [MDB-1:0] w);
      bit rdy, ok;
      ok = 1'b0;
      s_valid = 1'b1;
      s_data  = w;
      for (int i = 0; i < 500 && !ok; i++) begin
         rdy = s_ready;
         @(negedge clk);
         ok = rdy;
      end
      s_valid = 1'b0;
      chk1("send_accepted", ok, 1'b1);
   endtask

   task automatic grab(input int n);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (tx === 1'b0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk1("start_seen", ok, 1'b1);
      for (int c = 0; c < n; c++) begin
         cap_tx[c]   = tx;
         cap_done[c] = frame_done;
         cap_busy[c] = busy;
         if (c < n - 1) @(negedge clk);
      end
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk1("rst_tx", tx, 1'b1);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_s_ready", s_ready, 1'b1);
      chk1("rst_frame_done", frame_done, 1'b0);
      chk1("rst_cfg_err", cfg_err, 1'b0);
   endtask

   logic [9:0]  pat10;
   logic [10:0] pat11;
   int          a, cnt;
   int          bad_bits[4] = '{4, 10, 8, 8};
   int          bad_par[4]  = '{0, 0, 5, 7};

   initial begin
      @(posedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      reset_pulse();

      // 8N1, div 3, 0xA5
      cfg_div = 16'd3; cfg_data_bits = 4'd8; cfg_parity = 3'd0; cfg_stop2 = 1'b0;
      send(9'h0A5);
      grab(44);
      pat10 = 10'b1101001010;
      for (int b = 0; b < 10; b++) begin
         chk1("t1_bit_first", cap_tx[b*4], pat10[b]);
         chk1("t1_bit_last", cap_tx[b*4+3], pat10[b]);
      end
      chk1("t1_done39", cap_done[39], 1'b0);
      chk1("t1_done40", cap_done[40], 1'b1);

      // 7O2, div 0, 0x03
      cfg_div = 16'd0; cfg_data_bits = 4'd7; cfg_parity = 3'd2; cfg_stop2 = 1'b1;
      send(9'h003);
      grab(14);
      pat11 = 11'b11100000110;
      for (int b = 0; b < 11; b++) chk1("t2_bit", cap_tx[b], pat11[b]);
      cnt = 0;
      for (int c = 0; c < 14; c++) if (cap_busy[c] === 1'b1) cnt++;
      chkn("t2_busy_clks", cnt, 11);
      chk1("t2_done11", cap_done[11], 1'b1);

      // three words back-to-back, div 1
      cfg_div = 16'd1; cfg_data_bits = 4'd8; cfg_parity = 3'd0; cfg_stop2 = 1'b0;
      done_t.delete();
      send(9'h011);
      a = cyc;
      send(9'h022);
      chk1("t3_sready_held", s_ready, 1'b0);
      send(9'h033);
      for (int i = 0; i < 200 && done_t.size() < 3; i++) @(negedge clk);
      chkn("t3_frames", done_t.size(), 3);
      chkn("t3_done0", (done_t.size() > 0) ? done_t[0] : -1, a + 21);
      chkn("t3_done1", (done_t.size() > 1) ? done_t[1] : -1, a + 41);
      chkn("t3_done2", (done_t.size() > 2) ? done_t[2] : -1, a + 61);
      repeat (3) @(negedge clk);

      // boundary widths: 9 bits even parity, 5 bits mark parity two stops
      cfg_div = 16'd0; cfg_data_bits = 4'd9; cfg_parity = 3'd1; cfg_stop2 = 1'b0;
      send(9'h1FF);
      grab(14);
      chk1("t9_msb", cap_tx[9], 1'b1);
      chk1("t9_parity", cap_tx[10], 1'b1);
      chk1("t9_done12", cap_done[12], 1'b1);
      cfg_data_bits = 4'd5; cfg_parity = 3'd3; cfg_stop2 = 1'b1;
      send(9'h01E);
      grab(12);
      chk1("t5_bit0", cap_tx[1], 1'b0);
      chk1("t5_bit1", cap_tx[2], 1'b1);
      chk1("t5_mark", cap_tx[6], 1'b1);
      chk1("t5_done9", cap_done[9], 1'b1);

      // illegal configurations discard the word
      for (int k = 0; k < 4; k++) begin
         reset_pulse();
         cfg_data_bits = 4'(bad_bits[k]); cfg_parity = 3'(bad_par[k]); cfg_stop2 = 1'b0;
         done_t.delete();
         send(9'h155);
         repeat (12) @(negedge clk);
         chk1("t4_cfg_err", cfg_err, 1'b1);
         chk1("t4_s_ready", s_ready, 1'b1);
         chk1("t4_busy", busy, 1'b0);
         chkn("t4_no_frame", done_t.size(), 0);
      end

      // reset mid-frame at data bit 3, then a fresh frame
      reset_pulse();
      cfg_div = 16'd3; cfg_data_bits = 4'd8; cfg_parity = 3'd0; cfg_stop2 = 1'b0;
      send(9'h000);
      grab(18);
      chk1("t5_mid_low", cap_tx[17], 1'b0);
      reset_pulse();
      send(9'h05A);
      grab(44);
      pat10 = 10'b1010110100;
      for (int b = 0; b < 10; b++) chk1("t5_bit", cap_tx[b*4+2], pat10[b]);
      chk1("t5_done40", cap_done[40], 1'b1);

`ifdef UART_TX_BREAK_EN
      // break takes priority over a held word, then the word follows gaplessly
      reset_pulse();
      cfg_div = 16'd1; cfg_data_bits = 4'd8; cfg_parity = 3'd0; cfg_stop2 = 1'b0;
      s_valid = 1'b1; s_data = 9'h0C3;
      @(negedge clk);
      s_valid = 1'b0; brk_req = 1'b1;
      @(negedge clk);
      brk_req = 1'b0;
      for (int c = 0; c < 24; c++) begin
         cap_tx[c]  = tx;
         cap_brk[c] = brk_active;
         @(negedge clk);
      end
      cnt = 0;
      for (int c = 0; c < 24; c++) begin
         if (cap_tx[c] !== 1'b0) break;
         cnt++;
      end
      chkn("t6_low_clks", cnt, 20);
      chk1("t6_stop_a", cap_tx[20], 1'b1);
      chk1("t6_stop_b", cap_tx[21], 1'b1);
      chk1("t6_brk_on", cap_brk[0], 1'b1);
      chk1("t6_brk_stop", cap_brk[21], 1'b1);
      chk1("t6_brk_off", cap_brk[22], 1'b0);
      chk1("t6_held_start", cap_tx[22], 1'b0);
      repeat (30) @(negedge clk);
`endif

      repeat (4) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
